// File: rtl/rr_serial_router.sv
// Bit-serial NUM_PORTS x NUM_PORTS crossbar router. Each input runs an address/wait/transfer
// FSM; each output has a round-robin arbiter; output pins are registered (1-cycle latency).

module rr_serial_router #(
  parameter int unsigned NUM_PORTS = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] din,
  input  logic [NUM_PORTS-1:0] frame_n,
  input  logic [NUM_PORTS-1:0] valid_n,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] err,
  output logic [NUM_PORTS-1:0] dout,
  output logic [NUM_PORTS-1:0] frameo_n,
  output logic [NUM_PORTS-1:0] valido_n
);

  localparam int unsigned CntW = $clog2(ADDR_W + 1);

  typedef enum logic [1:0] {StIdle, StAddr, StWait, StXfer} state_e;

  state_e            state_q [NUM_PORTS];
  state_e            state_d [NUM_PORTS];
  logic [ADDR_W-1:0] dest_q  [NUM_PORTS];
  logic [ADDR_W-1:0] dest_d  [NUM_PORTS];
  logic [CntW-1:0]   cnt_q   [NUM_PORTS];
  logic [CntW-1:0]   cnt_d   [NUM_PORTS];
  logic [ADDR_W-1:0] ptr_q   [NUM_PORTS];
  logic [ADDR_W-1:0] ptr_d   [NUM_PORTS];

  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [NUM_PORTS-1:0] dout_q, dout_d;
  logic [NUM_PORTS-1:0] frameo_q, frameo_d;
  logic [NUM_PORTS-1:0] valido_q, valido_d;
  logic [NUM_PORTS-1:0] req, win, busy, xfer;

  // Address arrives LSB first: shift in at the top so the first bit lands in bit 0.
  function automatic logic [ADDR_W-1:0] shift_in(input logic [ADDR_W-1:0] a, input logic b);
    logic [ADDR_W-1:0] r;
    r = a >> 1;
    r[ADDR_W-1] = b;
    return r;
  endfunction

  // Requests drop in the same cycle frame_n rises, so an abort always beats a grant.
  always_comb begin
    req  = '0;
    xfer = '0;
    busy = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      xfer[i] = (state_q[i] == StXfer);
      req[i]  = (state_q[i] == StWait) && !frame_n[i];
    end
    for (int d = 0; d < NUM_PORTS; d++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (xfer[i] && (dest_q[i] == ADDR_W'(d))) busy[d] = 1'b1;
      end
    end
  end

  always_comb begin : arb
    logic              found;
    logic [ADDR_W-1:0] k;
    win   = '0;
    found = 1'b0;
    k     = '0;
    for (int d = 0; d < NUM_PORTS; d++) begin
      ptr_d[d] = ptr_q[d];
    end
    for (int d = 0; d < NUM_PORTS; d++) begin
      if (!busy[d]) begin
        found = 1'b0;
        for (int off = 0; off < NUM_PORTS; off++) begin
          k = ptr_q[d] + ADDR_W'(off);  // wraps modulo NUM_PORTS
          if (!found && req[k] && (dest_q[k] == ADDR_W'(d))) begin
            found    = 1'b1;
            win[k]   = 1'b1;
            ptr_d[d] = k + ADDR_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    err_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i] = state_q[i];
      dest_d[i]  = dest_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StIdle: begin
          if (!frame_n[i]) begin
            dest_d[i]  = shift_in(dest_q[i], din[i]);
            cnt_d[i]   = CntW'(1);
            state_d[i] = (ADDR_W == 1) ? StWait : StAddr;
          end
        end
        StAddr: begin
          if (frame_n[i]) begin
            err_d[i]   = 1'b1;
            state_d[i] = StIdle;
          end else begin
            dest_d[i] = shift_in(dest_q[i], din[i]);
            if (cnt_q[i] == CntW'(ADDR_W - 1)) begin
              state_d[i] = StWait;
            end else begin
              cnt_d[i] = cnt_q[i] + CntW'(1);
            end
          end
        end
        StWait: begin
          if (frame_n[i]) begin
            err_d[i]   = 1'b1;
            state_d[i] = StIdle;
          end else if (win[i]) begin
            state_d[i] = StXfer;
          end
        end
        StXfer: begin
          if (frame_n[i]) state_d[i] = StIdle;
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // At most one input is in transfer toward any output, so the loop selects a single owner.
  always_comb begin
    frameo_d = '1;
    valido_d = '1;
    dout_d   = '0;
    for (int d = 0; d < NUM_PORTS; d++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (xfer[i] && (dest_q[i] == ADDR_W'(d))) begin
          frameo_d[d] = frame_n[i];
          valido_d[d] = valid_n[i];
          dout_d[d]   = din[i] & ~valid_n[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= StIdle;
        dest_q[i]  <= '0;
        cnt_q[i]   <= '0;
        ptr_q[i]   <= '0;
      end
      err_q    <= '0;
      dout_q   <= '0;
      frameo_q <= '1;
      valido_q <= '1;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
      frameo_q <= frameo_d;
      valido_q <= valido_d;
    end
  end

  assign grant    = xfer;
  assign err      = err_q;
  assign dout     = dout_q;
  assign frameo_n = frameo_q;
  assign valido_n = valido_q;

endmodule

// File: doc/rr_serial_router.md
Name: rr_serial_router

Overview:
- Parametrised successor of the 16-port serial crossbar router. Each input port carries a bit-serial frame: a destination address, a wait phase, then payload.
- Per-output round-robin arbitration replaces arrival-order queuing. An explicit grant handshake replaces fixed padding, and frame errors are reported.
- Sits between the serial port drivers and the output port monitors.

Parameters:
- NUM_PORTS, 16, number of input ports and number of output ports; power of 2, range 2..32.
- ADDR_W, 4, destination address bits; equals log2(NUM_PORTS).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  NUM_PORTS  serial data, one bit per input port.
- frame_n  in  NUM_PORTS  active-low frame per input port.
- valid_n  in  NUM_PORTS  active-low payload-bit valid per input port.
- grant  out  NUM_PORTS  high while input i owns its destination output.
- err  out  NUM_PORTS  one-cycle pulse on a malformed or aborted frame.
- dout  out  NUM_PORTS  serial data per output port.
- frameo_n  out  NUM_PORTS  active-low frame per output port.
- valido_n  out  NUM_PORTS  active-low valid per output port.

Behaviour:
- Reset (sampled at clock edge): grant=0, err=0, dout=0, frameo_n=all 1, valido_n=all 1. All input FSMs go to IDLE, all outputs are free, all RR pointers=0. Reset mid-packet aborts the packet silently (no err).
- Input FSM states: IDLE, ADDR, WAIT, XFER.
- IDLE:
  - frame_n[i]=0 → capture din[i] as addr bit 0, set cnt=1, go to ADDR.
  - frame_n[i]=1 → stay in IDLE.
- ADDR: each cycle capture din[i] into addr bit cnt (LSB first), cnt++.
  - After bit ADDR_W-1 is captured → go to WAIT.
  - frame_n[i]=1 in any ADDR cycle → pulse err[i] next cycle, go to IDLE.
- WAIT: req[i]=1 toward dest[i]. din and valid_n are ignored.
  - frame_n[i]=1 while waiting → withdraw request, pulse err[i], go to IDLE.
  - If the grant and frame_n rising coincide, the abort wins and the grant is not issued.
- Arbiter, one per output d:
  - When d is free and requests exist, grant the lowest index k at or above ptr[d] (wrapping modulo NUM_PORTS).
  - Register the grant: grant[k]=1 on the next cycle; input k goes to XFER; d becomes busy; ptr[d]=(k+1) mod NUM_PORTS.
- XFER:
  - Each cycle with grant[i]=1, output d=dest[i] registers: frameo_n[d]<=frame_n[i], valido_n[d]<=valid_n[i], dout[d]<=(valid_n[i]==0)?din[i]:0. Latency is 1 cycle; the output mirrors the input.
  - The cycle in which frame_n[i]=1 is the last payload cycle; its bit is forwarded if valid_n[i]=0.
  - On the next cycle: grant[i]=0, input goes to IDLE, d is free.
- Output spacing:
  - frameo_n[d] stays high at least 1 cycle between packets.
  - The earliest next grant on d is issued in the cycle d becomes free; it is visible 1 cycle later.
- Output mapping rules:
  - Unowned outputs drive frameo_n=1, valido_n=1, dout=0.
  - An output is owned by at most one input at any time.
- Source requirement: hold valid_n[i]=1 until grant[i] is seen high.
- Self-addressing (dest=i) is legal.
- Inputs targeting different outputs transfer concurrently.
- An input may start a new frame the cycle after returning to IDLE.

Test Plan:
- Single packet (NUM_PORTS=16): port 3 sends addr 0xA (bits 0,1,0,1) then payload 1,0,1,1 with valid_n=0.
  - Expected: grant[3] rises 2 cycles after the last addr bit.
  - Expected: dout[10] shows 1,0,1,1 with valido_n[10]=0, each bit 1 cycle after its input.
  - Expected: frameo_n[10] rises 1 cycle after frame_n[3] rises.
- Contention: ports 2, 5 and 9 all finish addr 7 in the same cycle.
  - Expected: grants issued in order 2, 5, 9; no frameo_n[7] overlap; ≥1 idle cycle between packets.
  - Then ports 2 and 5 request 7 again simultaneously → expected: 2 granted (ptr=10 wraps to 2).
- Valid gaps: payload sent with valid_n=1 on 2 of 6 cycles.
  - Expected: valido_n[d]=1 and dout[d]=0 on exactly those cycles; the frame is not terminated.
- Errors:
  - frame_n rises after 2 addr bits → expected: err pulse 1 cycle, no grant.
  - frame_n rises during WAIT behind a busy output → expected: err pulse, request dropped, next waiter granted.
- Reset mid-XFER:
  - Expected: next cycle all frameo_n/valido_n=1, dout=0, grant=0, no err.
  - A new packet after reset routes correctly with ptr=0.
- NUM_PORTS=4, ADDR_W=2: 4 ports concurrently to 4 distinct outputs (permutation 1,2,3,0).
  - Expected: all 4 grants arrive in the same cycle and all payloads route intact.
